fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 SHALL have port r_clk  input  1  read-domain clock; all state updates on rising edge.
REQ-003 SHALL have port r_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rd_en  input  1  drain enable; 0 stops new pops, stream output continues.
REQ-005 SHALL have port r_empty  input  1  FIFO empty flag from FIFO read side.
REQ-006 SHALL have port r_data  input  DATA_WIDTH  FIFO head word, valid whenever r_empty=0 (fall-through).
REQ-007 SHALL have port r_inc  output  1  FIFO pop strobe; one word removed per rising edge with r_inc=1.
REQ-008 SHALL have port m_valid  output  1  stream word available.
REQ-009 SHALL have port m_ready  input  1  downstream accepts word.
REQ-010 SHALL have port m_data  output  DATA_WIDTH  stream word.

Function
REQ-011 SHALL hold a 2-entry output buffer (slot0 = head, slot1 = skid) with state EMPTY, ONE or TWO.
REQ-012 SHALL drive r_inc = rd_en & ~r_empty & (state != TWO) & ~r_reset; r_inc SHALL NOT depend on m_ready.
REQ-013 SHALL capture r_data into the first free slot on each edge where r_inc=1 (pop).
REQ-014 SHALL define take = m_valid & m_ready; m_valid = (state != EMPTY); m_data = slot0.
REQ-015 Transitions: EMPTY+pop -> ONE; ONE+pop+take -> ONE (slot0 <= r_data); ONE+pop+~take -> TWO; ONE+~pop+take -> EMPTY; TWO+take -> ONE (slot0 <= slot1); otherwise hold.
REQ-016 SHALL deliver words in exact FIFO order, with no loss or duplication, under any m_ready pattern.
REQ-017 Latency: word popped at edge k SHALL appear with m_valid=1 immediately after edge k when buffer was EMPTY.
REQ-018 With m_ready held 1 and r_empty held 0, SHALL sustain one word per cycle (r_inc=1 every cycle).
REQ-019 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-020 rd_en deassert SHALL stop pops at the same edge; buffered words SHALL still be delivered.
REQ-021 r_empty rising while state ONE/TWO SHALL not affect buffered words.

Reset
REQ-022 r_reset=1 SHALL immediately force state EMPTY, m_valid=0, r_inc=0, m_data=0, slots=0, independent of r_clk.
REQ-023 Reset mid-operation SHALL discard buffered words; no pop SHALL occur on any edge with r_reset=1.
REQ-024 First pop after reset release SHALL occur on the first edge with r_reset=0, rd_en=1, r_empty=0.

Configuration
REQ-025 Macro FIFO_RD_CNT_EN defined: SHALL add output rd_count [15:0] counting takes, reset 0, saturating at 65535.
REQ-026 Macro FIFO_RD_CNT_EN undefined: rd_count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Write 0x11,0x22,0x33 to FIFO, rd_en=1, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive m_valid cycles, r_empty=1 afterwards.
REQ-028 FIFO holds 4 words, m_ready=0 -> exactly 2 pops, state TWO, r_inc=0, m_data stable at first word; m_ready=1 -> all 4 delivered in order.
REQ-029 m_ready toggling 1,0,1,0 over 16 words (0x00..0x0F) -> output sequence 0x00..0x0F exactly, no gaps in order.
REQ-030 rd_en=0 with r_empty=0 -> r_inc=0 for all cycles, m_valid=0; rd_en=1 -> first word out one cycle later.
REQ-031 Assert r_reset mid-stream in state TWO -> m_valid=0 and r_inc=0 asynchronously; after release remaining FIFO words resume in order.
REQ-032 With FIFO_RD_CNT_EN, 10 takes -> rd_count=10; forced 65540 takes -> rd_count=65535.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a fall-through FIFO read port into a valid/ready stream.
// A two-entry buffer (head + skid) lets the pop strobe ignore m_ready. The pop
// decision depends only on buffer occupancy, so no combinational path runs from
// the downstream back to the FIFO.
// Optional feature: define FIFO_RD_CNT_EN to add a saturating 16-bit count of
// accepted stream words on rd_count.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_reset,
  input  logic                  rd_en,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_slot0;
  logic [DATA_WIDTH-1:0] r_slot1;

  logic [1:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] w_slot0_nxt;
  logic [DATA_WIDTH-1:0] w_slot1_nxt;
  logic                  w_pop;
  logic                  w_take;

  // Pop and take strobes. Reset gates the pop combinationally so the FIFO
  // never loses a word while the buffer is being cleared.
  always_comb begin
    w_pop   = rd_en & ~r_empty & (r_state != StTwo) & ~r_reset;
    m_valid = (r_state != StEmpty);
    w_take  = m_valid & m_ready;
    r_inc   = w_pop;
    m_data  = r_slot0;
  end

  // Buffer next-state: a pop fills the first free slot; a take shifts the skid forward.
  always_comb begin
    w_state_nxt = r_state;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    case (r_state)
      StEmpty: begin
        if (w_pop) begin
          w_slot0_nxt = r_data;
          w_state_nxt = StOne;
        end
      end
      StOne: begin
        if (w_pop && w_take) begin
          w_slot0_nxt = r_data;
        end else if (w_pop) begin
          w_slot1_nxt = r_data;
          w_state_nxt = StTwo;
        end else if (w_take) begin
          w_state_nxt = StEmpty;
        end
      end
      StTwo: begin
        if (w_take) begin
          w_slot0_nxt = r_slot1;
          w_state_nxt = StOne;
        end
      end
      default: begin
        w_state_nxt = StEmpty;
      end
    endcase
  end

  // Buffer state and slot registers.
  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      r_state <= StEmpty;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [15:0] r_count;

  // Saturating count of accepted stream words.
  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      r_count <= '0;
    end else if (w_take && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign rd_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a FIFO model feeds the DUT, and a queue-based
// scoreboard predicts the stream output. A vector table covers back-pressure
// with a full skid buffer. Directed sequences cover reset and rd_en gating,
// and a random phase follows.
module tb_fifo_rd_stream;

  logic       r_clk = 1'b0;
  logic       r_reset;
  logic       rd_en;
  logic       r_empty;
  logic [7:0] r_data;
  logic       r_inc;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .r_clk   (r_clk),
    .r_reset (r_reset),
    .rd_en   (rd_en),
    .r_empty (r_empty),
    .r_data  (r_data),
    .r_inc   (r_inc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  always #5 r_clk = ~r_clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];   // words still in the upstream FIFO
  logic [7:0] sb[$];       // words popped but not yet taken, in order
  logic [7:0] taken_q[$];  // words actually accepted downstream
  logic [7:0] exp_q[$];
  int unsigned tot_takes = 0;

  typedef struct {
    logic       rd_en;
    logic       m_ready;
    logic       exp_inc;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    r_empty = (fifo_q.size() == 0);
    r_data  = r_empty ? 8'($urandom) : fifo_q[0];
  endtask

  task automatic model_check();
    chk("m_valid", {31'd0, m_valid}, {31'd0, sb.size() != 0});
    chk("r_inc", {31'd0, r_inc},
        {31'd0, rd_en && fifo_q.size() != 0 && sb.size() < 2 && !r_reset});
    if (sb.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, sb[0]});
  endtask

  // Capture handshakes just before the edge, then update FIFO and scoreboard.
  task automatic advance();
    logic pi, pt;
    logic [7:0] pd;
    pi = r_inc;
    pt = m_valid && m_ready;
    pd = m_data;
    @(posedge r_clk);
    #1;
    if (pt) begin
      taken_q.push_back(pd);
      tot_takes++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (pi && fifo_q.size() != 0) sb.push_back(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic step();
    @(negedge r_clk);
    model_check();
    advance();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    rd_en   = 1'b1;
    m_ready = 1'b1;
    while ((fifo_q.size() != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drain_done"}, {31'd0, fifo_q.size() == 0 && sb.size() == 0}, 32'd1);
  endtask

  task automatic check_taken(input string name);
    chk({name, "_count"}, taken_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < taken_q.size(); i++)
      chk({name, "_order"}, {24'd0, taken_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  initial begin
    // Skid-buffer fill and release with four queued words A1..A4.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA2};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA4};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    r_reset = 1'b1;
    rd_en   = 1'b1;
    m_ready = 1'b0;
    drive_fifo();
    push(8'h99);  // present during reset: must not be popped
    drive_fifo();
    #3;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_r_inc", {31'd0, r_inc}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    @(posedge r_clk);
    #1;
    chk("rst_no_pop", {31'd0, r_inc}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    #1;
    r_reset = 1'b0;

    // Table: back-pressure fills the buffer to two, then releases.
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    drive_fifo();
    for (int i = 0; i < 9; i++) begin
      rd_en   = vecs[i].rd_en;
      m_ready = vecs[i].m_ready;
      @(negedge r_clk);
      chk($sformatf("vec%0d_r_inc", i), {31'd0, r_inc}, {31'd0, vecs[i].exp_inc});
      chk($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vecs[i].exp_data});
      advance();
    end
    check_taken("vec");

    // Three words, streaming at full rate.
    taken_q.delete(); exp_q.delete();
    push(8'h11); push(8'h22); push(8'h33);
    drive_fifo();
    drain("three", 20);
    check_taken("three");
    chk("three_empty", {31'd0, r_empty}, 32'd1);

    // Sixteen words with m_ready toggling.
    taken_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) push(8'(i));
    drive_fifo();
    rd_en = 1'b1;
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || sb.size() != 0); i++) begin
      m_ready = ~i[0];
      step();
    end
    drain("toggle", 10);
    check_taken("toggle");

    // rd_en low holds off pops; the first word appears one cycle after enabling.
    taken_q.delete(); exp_q.delete();
    push(8'h5A); push(8'h5B);
    drive_fifo();
    rd_en   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rd_en = 1'b1;
    @(negedge r_clk);
    chk("en_first_inc", {31'd0, r_inc}, 32'd1);
    chk("en_first_valid", {31'd0, m_valid}, 32'd0);
    advance();
    @(negedge r_clk);
    chk("en_next_valid", {31'd0, m_valid}, 32'd1);
    chk("en_next_data", {24'd0, m_data}, 32'h5A);
    advance();
    drain("en", 10);
    check_taken("en");

    // Reset while the buffer holds two words.
    taken_q.delete(); exp_q.delete();
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'h30 + 8'(i));
    drive_fifo();
    rd_en   = 1'b1;
    m_ready = 1'b0;
    step(); step(); step();
    chk("pre_rst_two", sb.size(), 32'd2);
    #2;
    r_reset = 1'b1;
    #1;
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_r_inc", {31'd0, r_inc}, 32'd0);
    chk("arst_m_data", {24'd0, m_data}, 32'd0);
    sb.delete();
    tot_takes = 0;
    @(negedge r_clk);
    model_check();
    advance();
    chk("arst_fifo_kept", fifo_q.size(), 32'd4);
    #2;
    r_reset = 1'b0;
    for (int i = 3; i <= 6; i++) exp_q.push_back(8'h30 + 8'(i));
    drain("rst", 20);
    check_taken("rst");

    // Random traffic against the scoreboard.
    taken_q.delete(); exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      rd_en   = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) push(8'($urandom));
      drive_fifo();
      step();
    end
    drain("rand", 4000);
    check_taken("rand");

`ifdef FIFO_RD_CNT_EN
    chk("cnt_match", {16'd0, rd_count}, (tot_takes > 65535) ? 32'd65535 : tot_takes);
    rd_en   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      fifo_q.push_back(8'(i));
      drive_fifo();
      @(negedge r_clk);
      advance();
    end
    chk("cnt_sat", {16'd0, rd_count}, 32'd65535);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
